gh_fifo_sync_lvl_wf: RTL and testbench

//   Single-clock, parametrised FIFO with UART-style fill-level flags and a programmable

---
 rtl/gh_fifo_sync_lvl_wf.sv | 109 ++++++++++
 tb/tb_gh_fifo_sync_lvl_wf.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gh_fifo_sync_lvl_wf.sv
// Single-clock FIFO with UART-style fill-level flags, programmable trigger and occupancy count.
// Optional sticky overrun flag is built only when GH_FIFO_OVERRUN_EN is defined.
module gh_fifo_sync_lvl_wf #(
    parameter int DATA_WIDTH = 11,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [1:0]            trig_lvl,
    input  logic                  ovr_clr,
    output logic [DATA_WIDTH-1:0] q,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  q_full,
    output logic                  h_full,
    output logic                  a_full,
    output logic                  trig,
    output logic                  overrun
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] LVL_ONE  = CW'(1);
    localparam logic [CW-1:0] LVL_QTR  = CW'(DEPTH / 4);
    localparam logic [CW-1:0] LVL_HALF = CW'(DEPTH / 2);
    localparam logic [CW-1:0] LVL_ALM  = CW'(DEPTH - 2);
    localparam logic [CW-1:0] LVL_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  wa;
    logic                  ra;
    logic [CW-1:0]         trig_level;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign wa = wr & (~full | rd);
    assign ra = rd & ~empty;

    assign q = mem[rd_ptr];

    assign empty  = (count == '0);
    assign full   = (count == LVL_FULL);
    assign q_full = (count >= LVL_QTR);
    assign h_full = (count >= LVL_HALF);
    assign a_full = (count >= LVL_ALM);

    always_comb begin
        trig_level = LVL_ONE;
        case (trig_lvl)
            2'b00:   trig_level = LVL_ONE;
            2'b01:   trig_level = LVL_QTR;
            2'b10:   trig_level = LVL_HALF;
            default: trig_level = LVL_ALM;
        endcase
    end

    assign trig = (count >= trig_level);

    always_ff @(posedge clk) begin
        if (wa && !rst && !srst) begin
            mem[wr_ptr] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || srst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wa) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (ra) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wa, ra})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef GH_FIFO_OVERRUN_EN
    // A dropped write outranks a coincident clear so no overrun event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (wr && !wa) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end
`else
    logic ovr_clr_unused;
    assign ovr_clr_unused = ovr_clr;
    assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_gh_fifo_sync_lvl_wf.sv
// Self-checking bench for gh_fifo_sync_lvl_wf: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_gh_fifo_sync_lvl_wf;

    localparam int DW    = 11;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          srst = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] d = '0;
    logic [1:0]    trig_lvl = 2'b00;
    logic          ovr_clr = 1'b0;
    logic [DW-1:0] q;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          q_full;
    logic          h_full;
    logic          a_full;
    logic          trig;
    logic          overrun;

    int checkCount = 0;
    int failCount  = 0;

    int model_q[$];
    bit model_ovr = 1'b0;

    gh_fifo_sync_lvl_wf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .srst(srst), .wr(wr), .rd(rd), .d(d),
        .trig_lvl(trig_lvl), .ovr_clr(ovr_clr), .q(q), .count(count),
        .empty(empty), .full(full), .q_full(q_full), .h_full(h_full),
        .a_full(a_full), .trig(trig), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int levelFor(input logic [1:0] sel);
        case (sel)
            2'b00:   return 1;
            2'b01:   return DEPTH / 4;
            2'b10:   return DEPTH / 2;
            default: return DEPTH - 2;
        endcase
    endfunction

    task automatic checkAll();
        int n;
        n = model_q.size();
        checkOutput("count",   int'(count),   n);
        checkOutput("empty",   int'(empty),   int'(n == 0));
        checkOutput("full",    int'(full),    int'(n == DEPTH));
        checkOutput("q_full",  int'(q_full),  int'(n >= DEPTH / 4));
        checkOutput("h_full",  int'(h_full),  int'(n >= DEPTH / 2));
        checkOutput("a_full",  int'(a_full),  int'(n >= DEPTH - 2));
        checkOutput("trig",    int'(trig),    int'(n >= levelFor(trig_lvl)));
        checkOutput("overrun", int'(overrun), int'(model_ovr));
        if (n > 0) begin
            checkOutput("q", int'(q), model_q[0]);
        end
    endtask

    // One clock of traffic: drive, let the edge happen, advance the model, check.
    task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] dv,
                                 input logic s, input logic rs, input logic oc,
                                 input logic [1:0] tl);
        bit is_full;
        wr = w; rd = r; d = dv; srst = s; rst = rs; ovr_clr = oc; trig_lvl = tl;
        @(posedge clk);
        is_full = (model_q.size() == DEPTH);
        if (rs) begin
            model_q.delete();
            model_ovr = 1'b0;
        end else begin
`ifdef GH_FIFO_OVERRUN_EN
            if (w && is_full && !r) model_ovr = 1'b1;
            else if (oc)            model_ovr = 1'b0;
`endif
            if (s) begin
                model_q.delete();
            end else begin
                if (r && model_q.size() > 0) void'(model_q.pop_front());
                if (w && (!is_full || r))    model_q.push_back(int'(dv));
            end
        end
        #1;
        checkAll();
    endtask

    task automatic idle(input logic [1:0] tl);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, tl);
    endtask

    initial begin
        #2;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 2'b00);
        for (int t = 0; t < 4; t++) idle(t[1:0]);

        // Fill and drain in order
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, DW'(i), 1'b0, 1'b0, 1'b0, 2'b11);
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b11);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Flags and trigger levels at 4 and 8 words
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, DW'(8'h20 + i), 1'b0, 1'b0, 1'b0, 2'b01);
        for (int t = 0; t < 4; t++) idle(t[1:0]);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0, 2'b10);
        for (int t = 0; t < 4; t++) idle(t[1:0]);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0, 2'b11);

        // Overrun: write while full, then read on full
        applyStimulus(1'b1, 1'b0, 11'h7FF, 1'b0, 1'b0, 1'b0, 2'b11);
        idle(2'b11);
        applyStimulus(1'b1, 1'b0, 11'h7FF, 1'b0, 1'b0, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 2'b11);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, DW'(11'h500 + i), 1'b0, 1'b0, 1'b0, 2'b11);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Simultaneous wr&rd on empty
        applyStimulus(1'b1, 1'b1, 11'h155, 1'b0, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Soft clear with 10 words stored and a write in the same cycle
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, DW'(11'h100 + i), 1'b0, 1'b0, 1'b0, 2'b10);
        applyStimulus(1'b1, 1'b0, 11'h3C3, 1'b1, 1'b0, 1'b0, 2'b10);
        applyStimulus(1'b1, 1'b0, 11'h0AA, 1'b0, 1'b0, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reset in the middle of alternating traffic at 7 words
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, DW'(11'h200 + i), 1'b0, 1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 6; i++) applyStimulus(i[0] == 1'b0, i[0] == 1'b1, DW'(11'h280 + i), 1'b0, 1'b0, 1'b0, 2'b01);
        applyStimulus(1'b1, 1'b0, 11'h2FF, 1'b0, 1'b1, 1'b0, 2'b01);
        for (int t = 0; t < 4; t++) idle(t[1:0]);
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, DW'(11'h600 + i), 1'b0, 1'b0, 1'b0, 2'b11);
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b11);

        // Random traffic with phases biased towards filling and draining
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 200) % 2 == 0) ? 70 : 35;
            applyStimulus($urandom_range(0, 99) < wp,
                          $urandom_range(0, 99) < (100 - wp),
                          DW'($urandom),
                          $urandom_range(0, 199) == 0,
                          $urandom_range(0, 399) == 0,
                          $urandom_range(0, 19) == 0,
                          2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
